// File: rtl/surf4_i2c_pkg.sv
// rtl/surf4_i2c_pkg.sv - shared types and constants for the I2C core arbiter
package surf4_i2c_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWN   = 2'd1,
        ST_ABORT = 2'd2
    } arb_state_t;

    localparam int M0    = 0;
    localparam int M1    = 1;
    localparam int ADR_W = 7;
    localparam int DAT_W = 8;

    // Owner index (0 = m0, 1 = m1) to one-hot grant vector.
    function automatic logic [1:0] owner_gnt(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/surf4_i2c_wdog.sv
// rtl/surf4_i2c_wdog.sv - ack watchdog counter with sticky expiry flag
module surf4_i2c_wdog #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 11
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic run,
    input  logic term,
    input  logic clr,
    output logic expire,
    output logic flag
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    // A termination in the expiry cycle suppresses the expiry.
    assign expire = run & ~term & (cnt == LAST);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt  <= '0;
            flag <= 1'b0;
        end else begin
            if (!run || term || expire) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
            // Set has priority over clear.
            if (expire) begin
                flag <= 1'b1;
            end else if (clr) begin
                flag <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/surf4_i2c_arb.sv
// rtl/surf4_i2c_arb.sv - two-master WISHBONE arbiter in front of the I2C controller core
module surf4_i2c_arb
    import surf4_i2c_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int FIXED_PRIO     = 0,
    parameter int CNT_W          = 11
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             m0_cyc_i,
    input  logic             m0_stb_i,
    input  logic             m0_we_i,
    input  logic [ADR_W-1:0] m0_adr_i,
    input  logic [DAT_W-1:0] m0_dat_i,
    input  logic             m0_lock_i,
    output logic             m0_ack_o,
    output logic             m0_err_o,
    output logic             m0_rty_o,
    input  logic             m1_cyc_i,
    input  logic             m1_stb_i,
    input  logic             m1_we_i,
    input  logic [ADR_W-1:0] m1_adr_i,
    input  logic [DAT_W-1:0] m1_dat_i,
    input  logic             m1_lock_i,
    output logic             m1_ack_o,
    output logic             m1_err_o,
    output logic             m1_rty_o,
    output logic [DAT_W-1:0] m_dat_o,
    output logic             s_cyc_o,
    output logic             s_stb_o,
    output logic             s_we_o,
    output logic [ADR_W-1:0] s_adr_o,
    output logic [DAT_W-1:0] s_dat_o,
    input  logic             s_ack_i,
    input  logic             s_err_i,
    input  logic             s_rty_i,
    input  logic [DAT_W-1:0] s_dat_i,
    output logic [1:0]       gnt_o,
    output logic             timeout_o,
    input  logic             timeout_clr_i
);

    arb_state_t       state;
    logic             owner;
    logic             last_owner;
    logic             req0;
    logic             req1;
    logic             pick;
    logic             owning;
    logic             sel0;
    logic             sel1;
    logic             term;
    logic             wd_expire;
    logic             own_cyc;
    logic             own_stb;
    logic             own_we;
    logic             own_lock;
    logic [ADR_W-1:0] own_adr;
    logic [DAT_W-1:0] own_dat;

    assign req0 = m0_cyc_i & m0_stb_i;
    assign req1 = m1_cyc_i & m1_stb_i;

    // Ties go to the master that did not own the core last, unless m0 is fixed-priority.
    always_comb begin
        pick = 1'b0;
        if (req0 && req1) begin
            pick = (FIXED_PRIO != 0) ? 1'b0 : ~last_owner;
        end else if (req1) begin
            pick = 1'b1;
        end
    end

    always_comb begin
        own_cyc  = m0_cyc_i;
        own_stb  = m0_stb_i;
        own_we   = m0_we_i;
        own_lock = m0_lock_i;
        own_adr  = m0_adr_i;
        own_dat  = m0_dat_i;
        if (owner) begin
            own_cyc  = m1_cyc_i;
            own_stb  = m1_stb_i;
            own_we   = m1_we_i;
            own_lock = m1_lock_i;
            own_adr  = m1_adr_i;
            own_dat  = m1_dat_i;
        end
    end

    assign owning  = (state == ST_OWN);
    assign sel0    = owning & ~owner;
    assign sel1    = owning & owner;

    assign s_cyc_o = owning & own_cyc;
    assign s_stb_o = owning & own_cyc & own_stb;
    assign s_we_o  = owning & own_we;
    assign s_adr_o = owning ? own_adr : '0;
    assign s_dat_o = owning ? own_dat : '0;
    assign m_dat_o = s_dat_i;

    assign term    = s_stb_o & (s_ack_i | s_err_i | s_rty_i);

    // Terminations only reach the owner, and only while the core is really granted.
    assign m0_ack_o = sel0 & s_ack_i;
    assign m0_err_o = sel0 & (s_err_i | wd_expire);
    assign m0_rty_o = sel0 & s_rty_i;
    assign m1_ack_o = sel1 & s_ack_i;
    assign m1_err_o = sel1 & (s_err_i | wd_expire);
    assign m1_rty_o = sel1 & s_rty_i;

    surf4_i2c_wdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) u_wdog (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .run    (s_stb_o),
        .term   (term),
        .clr    (timeout_clr_i),
        .expire (wd_expire),
        .flag   (timeout_o)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= ST_IDLE;
            owner      <= 1'b0;
            last_owner <= 1'b1;
            gnt_o      <= 2'b00;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req0 || req1) begin
                        owner <= pick;
                        gnt_o <= owner_gnt(pick);
                        state <= ST_OWN;
                    end
                end
                ST_OWN: begin
                    if (wd_expire) begin
                        state <= ST_ABORT;
                    end else if ((term && !(own_lock && own_cyc)) || !own_cyc) begin
                        state      <= ST_IDLE;
                        last_owner <= owner;
                        gnt_o      <= 2'b00;
                    end
                end
                ST_ABORT: begin
                    // Hold the owner off the core until it abandons its cycle.
                    if (!own_cyc) begin
                        state      <= ST_IDLE;
                        last_owner <= owner;
                        gnt_o      <= 2'b00;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    gnt_o <= 2'b00;
                end
            endcase
        end
    end

endmodule
